// File: rtl/fetch_pkg.sv
// Fetch sequencer shared types.
// State encoding, timeout default and jump-mux select codes.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_state_t;

  localparam int unsigned TMO_DEF = 255;

  localparam logic PC_SEL_JMP = 1'b1;
  localparam logic PC_SEL_SEQ = 1'b0;

endpackage

// File: rtl/fetch_ibuf.sv
// One-entry hold buffer for an IMEM response.
// Catches rdata while decode is stalled; flush drops it.
module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // next-state: flush wins, push refills, pop empties
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: IMEM handshake, PC enable/select, IR.
// Squashes responses on redirect, buffers one on stall.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned bits = 32,
  parameter int unsigned TMO  = TMO_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            brjmp,
  input  logic            id_stall,
  input  logic            mem_rdy,
  input  logic            valid,
  input  logic [bits-1:0] rdata,
  output logic            proc_req,
  output logic            we,
  output logic            pc_en,
  output logic            pc_sel,
  output logic [bits-1:0] ir,
  output logic            ir_valid,
  output logic            stall,
  output logic            err
);

  localparam int CW = $clog2(TMO + 1);

  fetch_state_t    state_q, state_d;
  logic            squash_q, squash_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [bits-1:0] ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            err_q, err_d;

  logic            redir;
  logic            accept;
  logic            consume;
  logic            buf_full;
  logic            buf_push;
  logic            buf_pop;
  logic [bits-1:0] buf_data;

  assign redir    = brjmp && (state_q != S_IDLE);
  assign proc_req = (state_q == S_REQ) && !buf_full;
  assign accept   = proc_req && mem_rdy;
  assign consume  = (state_q == S_WAIT) && valid
                    && !squash_q && !redir;
  assign we       = 1'b0;
  assign stall    = ((state_q == S_REQ) && !accept && !buf_full)
                 || ((state_q == S_WAIT) && !valid);

  // PC load: redirect takes jpc, live response steps PC+4
  always_comb begin
    pc_en  = 1'b0;
    pc_sel = PC_SEL_SEQ;
    if (redir) begin
      pc_en  = 1'b1;
      pc_sel = PC_SEL_JMP;
    end else if (consume) begin
      pc_en  = 1'b1;
    end
  end

  // FSM next-state, squash flag, timeout counter, sticky err
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (accept) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          squash_d = redir;
        end
      end
      S_WAIT: begin
        if (cnt_q != CW'(TMO)) cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(TMO)) err_d = 1'b1;
        if (valid) begin
          state_d  = S_REQ;
          squash_d = 1'b0;
        end else if (redir) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IR load: drain buffer first, else take the live response
  always_comb begin
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;
    if (redir) begin
      ir_valid_d = 1'b0;
    end else if (!id_stall) begin
      if (buf_full) begin
        ir_d       = buf_data;
        ir_valid_d = 1'b1;
        buf_pop    = 1'b1;
        buf_push   = consume;
      end else if (consume) begin
        ir_d       = rdata;
        ir_valid_d = 1'b1;
      end else begin
        ir_valid_d = 1'b0;
      end
    end else if (consume) begin
      if (!ir_valid_q) begin
        ir_d       = rdata;
        ir_valid_d = 1'b1;
      end else begin
        buf_push   = 1'b1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      squash_q   <= 1'b0;
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
    end
  end

  fetch_ibuf #(
    .W(bits)
  ) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redir),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .data_i  (rdata),
    .data_o  (buf_data),
    .full_o  (buf_full)
  );

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign err      = err_q;

endmodule
